link1_mm_host_bridge: RTL

//  Host-side front end of the link1 register space. Sits directly upstream of the link1 address decoder.

---
 rtl/link1_mm_host_bridge_if.sv | 35 +++
 rtl/link1_mm_host_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/link1_mm_host_bridge_if.sv
// Host/decoder bus bundle for the link1 host bridge.
// The bridge connects through the slave modport; the environment (host plus decoder) connects through the master modport.
interface link1_mm_host_bridge_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0] iHOST_ADDR;
    logic [DATA_W-1:0] iHOST_WR_DATA;
    logic              iHOST_WR_EN;
    logic              iHOST_RD_EN;
    logic              oHOST_WAIT;
    logic [DATA_W-1:0] oHOST_RD_DATA;
    logic              oHOST_RD_DATA_V;
    logic              oHOST_RD_ERR;
    logic [ADDR_W-1:0] oMM_ADDR;
    logic [DATA_W-1:0] oMM_WR_DATA;
    logic              oMM_WR_EN;
    logic              oMM_RD_EN;
    logic [DATA_W-1:0] iMM_RD_DATA;
    logic              iMM_RD_DATA_V;

    modport slave (
        input  iHOST_ADDR, iHOST_WR_DATA, iHOST_WR_EN, iHOST_RD_EN,
        input  iMM_RD_DATA, iMM_RD_DATA_V,
        output oHOST_WAIT, oHOST_RD_DATA, oHOST_RD_DATA_V, oHOST_RD_ERR,
        output oMM_ADDR, oMM_WR_DATA, oMM_WR_EN, oMM_RD_EN
    );

    modport master (
        output iHOST_ADDR, iHOST_WR_DATA, iHOST_WR_EN, iHOST_RD_EN,
        output iMM_RD_DATA, iMM_RD_DATA_V,
        input  oHOST_WAIT, oHOST_RD_DATA, oHOST_RD_DATA_V, oHOST_RD_ERR,
        input  oMM_ADDR, oMM_WR_DATA, oMM_WR_EN, oMM_RD_EN
    );
endinterface

// File: rtl/link1_mm_host_bridge.sv
// Host-side front end of the link1 register space: turns held host requests into single-cycle decoder pulses,
// with one outstanding read, a read timeout that returns an error word, and counting of discarded responses.
module link1_mm_host_bridge #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned FLUSH_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    link1_mm_host_bridge_if.slave   bus,
    output logic [15:0]             oTIMEOUT_CNT,
    output logic [15:0]             oSTRAY_CNT
);
    localparam int unsigned CNT_MAX = (TIMEOUT > FLUSH_CYC) ? TIMEOUT : FLUSH_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mm_addr_q, mm_addr_d;
    logic [DATA_W-1:0] mm_wr_data_q, mm_wr_data_d;
    logic              mm_wr_en_q, mm_wr_en_d;
    logic              mm_rd_en_q, mm_rd_en_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_data_v_q, rd_data_v_d;
    logic              rd_err_q, rd_err_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       stray_cnt_q, stray_cnt_d;
    logic [DATA_W-1:0] err_word;

    logic accept, rsp_hit, timeout_hit, flush_done, stray;

    assign accept      = (state_q == IDLE) && (bus.iHOST_WR_EN || bus.iHOST_RD_EN);
    assign rsp_hit     = (state_q == RD_WAIT) && bus.iMM_RD_DATA_V;
    // A response arriving on the timeout cycle wins over the timeout.
    assign timeout_hit = (state_q == RD_WAIT) && !bus.iMM_RD_DATA_V && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign flush_done  = (state_q == FLUSH) && (cnt_q == CNT_W'(FLUSH_CYC - 1));
    assign stray       = bus.iMM_RD_DATA_V && (state_q != RD_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mm_addr_q    <= '0;
            mm_wr_data_q <= '0;
            mm_wr_en_q   <= 1'b0;
            mm_rd_en_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_data_v_q  <= 1'b0;
            rd_err_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            stray_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mm_addr_q    <= mm_addr_d;
            mm_wr_data_q <= mm_wr_data_d;
            mm_wr_en_q   <= mm_wr_en_d;
            mm_rd_en_q   <= mm_rd_en_d;
            rd_data_q    <= rd_data_d;
            rd_data_v_q  <= rd_data_v_d;
            rd_err_q     <= rd_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stray_cnt_q  <= stray_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.iHOST_RD_EN && !bus.iHOST_WR_EN) begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                if (rsp_hit) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (flush_done) state_d = IDLE;
                else            cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_word                    = '0;
        err_word[ADDR_W-1:0]        = mm_addr_q;
        err_word[DATA_W-1 -: 32]    = 32'hDEAD_BEEF;

        mm_addr_d    = mm_addr_q;
        mm_wr_data_d = mm_wr_data_q;
        mm_wr_en_d   = 1'b0;
        mm_rd_en_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_data_v_d  = 1'b0;
        rd_err_d     = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
        stray_cnt_d  = stray_cnt_q;

        if (accept) begin
            mm_addr_d = bus.iHOST_ADDR;
            // Simultaneous write+read: the write goes out, the read is refused with an error strobe.
            if (bus.iHOST_WR_EN) begin
                mm_wr_en_d   = 1'b1;
                mm_wr_data_d = bus.iHOST_WR_DATA;
                if (bus.iHOST_RD_EN) begin
                    rd_data_v_d = 1'b1;
                    rd_err_d    = 1'b1;
                    rd_data_d   = '0;
                end
            end else begin
                mm_rd_en_d = 1'b1;
            end
        end

        if (rsp_hit) begin
            rd_data_v_d = 1'b1;
            rd_data_d   = bus.iMM_RD_DATA;
        end

        if (timeout_hit) begin
            rd_data_v_d = 1'b1;
            rd_err_d    = 1'b1;
            rd_data_d   = err_word;
            if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        if (stray && (stray_cnt_q != '1)) stray_cnt_d = stray_cnt_q + 16'd1;
    end

    assign bus.oHOST_WAIT      = (state_q != IDLE);
    assign bus.oHOST_RD_DATA   = rd_data_q;
    assign bus.oHOST_RD_DATA_V = rd_data_v_q;
    assign bus.oHOST_RD_ERR    = rd_err_q;
    assign bus.oMM_ADDR        = mm_addr_q;
    assign bus.oMM_WR_DATA     = mm_wr_data_q;
    assign bus.oMM_WR_EN       = mm_wr_en_q;
    assign bus.oMM_RD_EN       = mm_rd_en_q;
    assign oTIMEOUT_CNT        = tmo_cnt_q;
    assign oSTRAY_CNT          = stray_cnt_q;
endmodule
